snake_move_ctrl: RTL and testbench

- Per-move sequencer for the snake body FIFO. The FIFO holds cell positions, oldest entry = tail, newest = head.
- On each game tick the block computes the new head, pops the tail (unless growing), checks wall and self collision against an occupancy bitmap, then pushes the head.
- Sits between the game timer/input logic and the body FIFO; drives draw/erase strobes to the renderer.

---
 rtl/snake_pkg.sv | 59 +++++
 rtl/snake_occ_map.sv | 41 ++++
 rtl/snake_move_ctrl.sv | 164 ++++++++++++++++
 tb/tb_snake_move_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared definitions for the snake move sequencer: direction codes, FSM
// state encoding and the one-cell step helper.
package snake_pkg;

    localparam int GRID_BITS = 4;
    localparam int PW        = 2 * GRID_BITS;

    localparam logic [GRID_BITS-1:0] GRID_MAX = {GRID_BITS{1'b1}};

    localparam logic [1:0] DIR_RIGHT = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_UP    = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_RDWAIT,
        ST_CHECK,
        ST_DEAD
    } state_t;

    typedef struct packed {
        logic [PW-1:0] pos;
        logic          wall;
    } step_t;

    // Position is {y,x}; y grows downward. Coordinates always wrap modulo the
    // grid, and wall flags the wrap so the caller decides whether it is fatal.
    function automatic step_t step(input logic [PW-1:0] pos, input logic [1:0] dir);
        logic [GRID_BITS-1:0] x;
        logic [GRID_BITS-1:0] y;
        step_t                r;
        x      = pos[GRID_BITS-1:0];
        y      = pos[PW-1:GRID_BITS];
        r.wall = 1'b0;
        case (dir)
            DIR_RIGHT: begin
                r.wall = (x == GRID_MAX);
                x      = x + 1'b1;
            end
            DIR_DOWN: begin
                r.wall = (y == GRID_MAX);
                y      = y + 1'b1;
            end
            DIR_LEFT: begin
                r.wall = (x == '0);
                x      = x - 1'b1;
            end
            default: begin
                r.wall = (y == '0);
                y      = y - 1'b1;
            end
        endcase
        r.pos = {y, x};
        return r;
    endfunction

endpackage

// File: rtl/snake_occ_map.sv
// One bit per grid cell marking cells covered by the snake body.
// Resets to the initial body: cells {y=0, x=0..INIT_LEN-1}.
module snake_occ_map #(
    parameter int PW       = 8,
    parameter int INIT_LEN = 3
) (
    input  logic          clk,
    input  logic          aclr_n,
    input  logic          set_en,
    input  logic [PW-1:0] set_idx,
    input  logic          clr_en,
    input  logic [PW-1:0] clr_idx,
    input  logic [PW-1:0] look_idx,
    output logic          look_hit
);
    import snake_pkg::*;

    localparam int CELLS = 2 ** PW;

    logic [CELLS-1:0] occ;

    // Clear (tail vacated) and set (head entered) never target the same move step.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            occ <= '0;
            for (int i = 0; i < INIT_LEN; i++) begin
                occ[i] <= 1'b1;
            end
        end else begin
            if (clr_en) begin
                occ[clr_idx] <= 1'b0;
            end
            if (set_en) begin
                occ[set_idx] <= 1'b1;
            end
        end
    end

    assign look_hit = occ[look_idx];

endmodule

// File: rtl/snake_move_ctrl.sv
// Per-move sequencer for the snake body FIFO (oldest entry = tail).
// Build option: define SNAKE_WRAP_EN to wrap coordinates at the grid edge
// instead of ending the game on a wall exit.
//
// The body FIFO is expected to be show-ahead: fifo_dout presents the current
// tail, and the tail is captured on the same edge that the pop takes effect.
//
// state  | meaning
// IDLE   | waiting for tick; latches the new direction
// CALC   | next head computed; wall and food decided; pop tail unless growing
// RDWAIT | popped tail captured, erased and cleared from the bitmap
// CHECK  | self-collision test; push head, draw, update length
// DEAD   | game over; only aclr_n leaves
module snake_move_ctrl #(
    parameter int GRID_BITS = snake_pkg::GRID_BITS,
    parameter int MAX_LEN   = 128,
    parameter int INIT_LEN  = 3
) (
    input  logic                   clk,
    input  logic                   aclr_n,
    input  logic                   tick,
    input  logic [1:0]             dir_req,
    input  logic                   food_valid,
    input  logic [2*GRID_BITS-1:0] food_pos,
    output logic                   fifo_rden,
    input  logic [2*GRID_BITS-1:0] fifo_dout,
    output logic                   fifo_wren,
    output logic [2*GRID_BITS-1:0] fifo_din,
    output logic [2*GRID_BITS-1:0] head_pos,
    output logic [7:0]             length,
    output logic                   draw_valid,
    output logic                   erase_valid,
    output logic [2*GRID_BITS-1:0] erase_pos,
    output logic                   ate,
    output logic                   busy,
    output logic                   game_over
);
    import snake_pkg::*;

    localparam int         PW         = 2 * GRID_BITS;
    localparam logic [7:0] MAX_LEN_V  = 8'(MAX_LEN);
    localparam logic [7:0] INIT_LEN_V = 8'(INIT_LEN);

    state_t        state;
    logic [1:0]    dir;
    logic [PW-1:0] nxt_pos;
    logic          grow;
    logic          food_hit;

    step_t         st;
    logic          wall_kill;
    logic          food_match;
    logic          can_grow;
    logic          occ_hit;

    assign st = step(head_pos, dir);

`ifdef SNAKE_WRAP_EN
    assign wall_kill = 1'b0;
`else
    assign wall_kill = st.wall;
`endif

    assign food_match = food_valid && (st.pos == food_pos);
    assign can_grow   = (length < MAX_LEN_V);

    snake_occ_map #(
        .PW       (PW),
        .INIT_LEN (INIT_LEN)
    ) u_occ (
        .clk      (clk),
        .aclr_n   (aclr_n),
        .set_en   ((state == ST_CHECK) && !occ_hit),
        .set_idx  (nxt_pos),
        .clr_en   (state == ST_RDWAIT),
        .clr_idx  (fifo_dout),
        .look_idx (nxt_pos),
        .look_hit (occ_hit)
    );

    // Move sequencer; all strobes default low so each is a single-cycle pulse.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state       <= ST_IDLE;
            dir         <= DIR_RIGHT;
            head_pos    <= PW'(INIT_LEN - 1);
            length      <= INIT_LEN_V;
            nxt_pos     <= '0;
            grow        <= 1'b0;
            food_hit    <= 1'b0;
            erase_pos   <= '0;
            fifo_rden   <= 1'b0;
            fifo_wren   <= 1'b0;
            fifo_din    <= '0;
            draw_valid  <= 1'b0;
            erase_valid <= 1'b0;
            ate         <= 1'b0;
            busy        <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            fifo_rden   <= 1'b0;
            fifo_wren   <= 1'b0;
            draw_valid  <= 1'b0;
            erase_valid <= 1'b0;
            ate         <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tick) begin
                        // A U-turn would run straight into the neck; keep heading.
                        if (dir_req != (dir ^ 2'b10)) begin
                            dir <= dir_req;
                        end
                        busy  <= 1'b1;
                        state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    nxt_pos  <= st.pos;
                    food_hit <= food_match;
                    grow     <= food_match && can_grow;
                    if (wall_kill) begin
                        busy      <= 1'b0;
                        game_over <= 1'b1;
                        state     <= ST_DEAD;
                    end else if (food_match && can_grow) begin
                        state <= ST_CHECK;
                    end else begin
                        fifo_rden <= 1'b1;
                        state     <= ST_RDWAIT;
                    end
                end
                ST_RDWAIT: begin
                    erase_pos   <= fifo_dout;
                    erase_valid <= 1'b1;
                    state       <= ST_CHECK;
                end
                ST_CHECK: begin
                    busy <= 1'b0;
                    if (occ_hit) begin
                        game_over <= 1'b1;
                        state     <= ST_DEAD;
                    end else begin
                        fifo_wren  <= 1'b1;
                        fifo_din   <= nxt_pos;
                        head_pos   <= nxt_pos;
                        draw_valid <= 1'b1;
                        ate        <= food_hit;
                        if (grow) begin
                            length <= length + 8'd1;
                        end
                        state <= ST_IDLE;
                    end
                end
                ST_DEAD: begin
                    state <= ST_DEAD;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Directed bench for snake_move_ctrl with a show-ahead body FIFO model.
module tb_snake_move_ctrl;

    logic       clk = 1'b0;
    logic       aclr_n = 1'b0;
    logic       tick = 1'b0;
    logic [1:0] dir_req = 2'd0;
    logic       food_valid = 1'b0;
    logic [7:0] food_pos = 8'h00;
    logic       fifo_rden;
    logic [7:0] fifo_dout;
    logic       fifo_wren;
    logic [7:0] fifo_din;
    logic [7:0] head_pos;
    logic [7:0] length;
    logic       draw_valid;
    logic       erase_valid;
    logic [7:0] erase_pos;
    logic       ate;
    logic       busy;
    logic       game_over;

    int n_chk = 0;
    int n_fail = 0;

    snake_move_ctrl dut (
        .clk         (clk),
        .aclr_n      (aclr_n),
        .tick        (tick),
        .dir_req     (dir_req),
        .food_valid  (food_valid),
        .food_pos    (food_pos),
        .fifo_rden   (fifo_rden),
        .fifo_dout   (fifo_dout),
        .fifo_wren   (fifo_wren),
        .fifo_din    (fifo_din),
        .head_pos    (head_pos),
        .length      (length),
        .draw_valid  (draw_valid),
        .erase_valid (erase_valid),
        .erase_pos   (erase_pos),
        .ate         (ate),
        .busy        (busy),
        .game_over   (game_over)
    );

    always #5 clk = ~clk;

    // Body FIFO model: show-ahead, reset to the initial body (tail first).
    logic [7:0] fmem [0:255];
    logic [7:0] wp;
    logic [7:0] rp;
    assign fifo_dout = fmem[rp];

    always @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            rp <= 8'd0;
            wp <= 8'd3;
            for (int i = 0; i < 3; i++) fmem[i] <= 8'(i);
        end else begin
            if (fifo_rden) rp <= rp + 8'd1;
            if (fifo_wren) begin
                fmem[wp] <= fifo_din;
                wp <= wp + 8'd1;
            end
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Observations of one move, indexed by cycle k after the tick-sampling edge.
    int         r_rden, r_erase, r_wren, r_draw, r_ate, r_over, n_wren, n_strb;
    logic [7:0] r_erpos, r_din;
    logic [15:0] r_busy;

    task automatic do_reset();
        aclr_n = 1'b0;
        tick = 1'b0;
        dir_req = 2'd0;
        food_valid = 1'b0;
        food_pos = 8'h00;
        repeat (2) @(negedge clk);
        aclr_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_move(input logic [1:0] d, input int ticks);
        r_rden = 0; r_erase = 0; r_wren = 0; r_draw = 0; r_ate = 0; r_over = 0;
        n_wren = 0; n_strb = 0; r_erpos = 8'hxx; r_din = 8'hxx; r_busy = '0;
        @(negedge clk);
        dir_req = d;
        tick = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k >= ticks) tick = 1'b0;
            if (fifo_rden && r_rden == 0) r_rden = k;
            if (erase_valid && r_erase == 0) begin r_erase = k; r_erpos = erase_pos; end
            if (fifo_wren) begin
                if (r_wren == 0) begin r_wren = k; r_din = fifo_din; end
                n_wren++;
            end
            if (draw_valid && r_draw == 0) r_draw = k;
            if (ate && r_ate == 0) r_ate = k;
            if (game_over && r_over == 0) r_over = k;
            if (fifo_rden || fifo_wren || erase_valid || draw_valid || ate) n_strb++;
            r_busy[k] = busy;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        do_reset();
        chk_eq("rst_head", head_pos, 8'h02);
        chk_eq("rst_len", length, 8'd3);
        chk_eq("rst_busy", busy, 1'b0);
        chk_eq("rst_over", game_over, 1'b0);
        chk_eq("rst_strb", {fifo_rden, fifo_wren, draw_valid, erase_valid, ate}, 5'b0);

        // Plain move right
        run_move(2'd0, 1);
        chk_eq("mv_rden_cyc", r_rden, 2);
        chk_eq("mv_erase_cyc", r_erase, 3);
        chk_eq("mv_erase_pos", r_erpos, 8'h00);
        chk_eq("mv_wren_cyc", r_wren, 4);
        chk_eq("mv_draw_cyc", r_draw, 4);
        chk_eq("mv_din", r_din, 8'h03);
        chk_eq("mv_ate", r_ate, 0);
        chk_eq("mv_head", head_pos, 8'h03);
        chk_eq("mv_len", length, 8'd3);
        chk_eq("mv_busy", r_busy[5:0], 6'b001110);
        chk_eq("mv_fifo_occ", 8'(wp - rp), 8'd3);

        // Grow onto food
        do_reset();
        food_valid = 1'b1;
        food_pos = 8'h03;
        run_move(2'd0, 1);
        food_valid = 1'b0;
        chk_eq("gr_rden", r_rden, 0);
        chk_eq("gr_erase", r_erase, 0);
        chk_eq("gr_wren_cyc", r_wren, 3);
        chk_eq("gr_din", r_din, 8'h03);
        chk_eq("gr_ate_cyc", r_ate, 3);
        chk_eq("gr_len", length, 8'd4);
        chk_eq("gr_fifo_occ", 8'(wp - rp), 8'd4);

        // Reverse request is ignored
        do_reset();
        run_move(2'd2, 1);
        chk_eq("rev_head", head_pos, 8'h03);
        chk_eq("rev_din", r_din, 8'h03);

        // Walk to the right wall then step past it
        do_reset();
        for (int m = 0; m < 13; m++) run_move(2'd0, 1);
        chk_eq("wall_pre_head", head_pos, 8'h0F);
        run_move(2'd0, 1);
`ifdef SNAKE_WRAP_EN
        chk_eq("wrap_head", head_pos, 8'h00);
        chk_eq("wrap_wren_cyc", r_wren, 4);
        chk_eq("wrap_erase_pos", r_erpos, 8'h0D);
        chk_eq("wrap_over", game_over, 1'b0);
`else
        chk_eq("wall_over_cyc", r_over, 2);
        chk_eq("wall_rden", r_rden, 0);
        chk_eq("wall_wren", r_wren, 0);
        chk_eq("wall_head", head_pos, 8'h0F);
        run_move(2'd1, 1);
        chk_eq("dead_strb", n_strb, 0);
        chk_eq("dead_busy", r_busy, 16'h0000);
        chk_eq("dead_over", game_over, 1'b1);
`endif

        // Length-5 snake turns back into its own body
        do_reset();
        food_valid = 1'b1;
        food_pos = 8'h03;
        run_move(2'd0, 1);
        food_pos = 8'h04;
        run_move(2'd0, 1);
        food_valid = 1'b0;
        chk_eq("sc_len", length, 8'd5);
        run_move(2'd1, 1);
        chk_eq("sc_down_head", head_pos, 8'h14);
        run_move(2'd2, 1);
        chk_eq("sc_left_head", head_pos, 8'h13);
        run_move(2'd3, 1);
        chk_eq("sc_rden_cyc", r_rden, 2);
        chk_eq("sc_erase_pos", r_erpos, 8'h02);
        chk_eq("sc_wren", r_wren, 0);
        chk_eq("sc_over_cyc", r_over, 4);
        chk_eq("sc_head", head_pos, 8'h13);
        run_move(2'd0, 1);
        chk_eq("sc_dead_strb", n_strb, 0);

        // Length-4 loop steps into the tail it just vacated
        do_reset();
        food_valid = 1'b1;
        food_pos = 8'h03;
        run_move(2'd0, 1);
        food_valid = 1'b0;
        run_move(2'd1, 1);
        run_move(2'd2, 1);
        run_move(2'd3, 1);
        chk_eq("tail_wren_cyc", r_wren, 4);
        chk_eq("tail_din", r_din, 8'h02);
        chk_eq("tail_over", game_over, 1'b0);
        chk_eq("tail_head", head_pos, 8'h02);

        // Back-to-back ticks: second one dropped
        do_reset();
        run_move(2'd0, 2);
        chk_eq("b2b_nwren", n_wren, 1);
        chk_eq("b2b_head", head_pos, 8'h03);
        chk_eq("b2b_busy", r_busy[5:0], 6'b001110);

        // Reset in the middle of a move
        do_reset();
        @(negedge clk);
        dir_req = 2'd1;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        chk_eq("mid_rden", fifo_rden, 1'b1);
        #1 aclr_n = 1'b0;
        #1;
        chk_eq("mid_rst_rden", fifo_rden, 1'b0);
        chk_eq("mid_rst_busy", busy, 1'b0);
        chk_eq("mid_rst_head", head_pos, 8'h02);
        chk_eq("mid_rst_len", length, 8'd3);
        chk_eq("mid_rst_fifo_occ", 8'(wp - rp), 8'd3);
        @(negedge clk);
        aclr_n = 1'b1;
        run_move(2'd0, 1);
        chk_eq("post_rst_din", r_din, 8'h03);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
